// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: upstream instruction handshake, regfile read ports,
// writeback snoop and the ID/EX output register.
interface operand_fetch_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    ex_op;
    logic [AW-1:0] ex_rd;
    logic          ex_wen;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [DW-1:0] ex_imm;
    logic          halted;

    // slave = the fetch stage itself, master = everything around it
    modport slave (
        input  instr_valid, instr, rdata1, rdata2, wb_en, wb_addr, wb_data, ex_ready,
        output instr_ready, raddr1, raddr2, ex_valid, ex_op, ex_rd, ex_wen,
               ex_a, ex_b, ex_imm, halted
    );

    modport master (
        output instr_valid, instr, rdata1, rdata2, wb_en, wb_addr, wb_data, ex_ready,
        input  instr_ready, raddr1, raddr2, ex_valid, ex_op, ex_rd, ex_wen,
               ex_a, ex_b, ex_imm, halted
    );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes, reads regfile with writeback forwarding,
// tracks pending writes in a busy scoreboard and fills the ID/EX register.
//
// state   | meaning
// ST_RUN  | instructions accepted normally
// ST_HALT | HALT issued; nothing accepted until reset
module operand_fetch #(
    parameter int DW    = 32,
    parameter int AW    = 4,
    parameter int NREGS = 16
) (
    input  logic clk,
    input  logic rst,
    operand_fetch_if.slave bus
);
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LUI  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t state, state_nxt;

    logic [3:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [15:0]   imm16;
    logic          uses_rs1, uses_rs2, writes_rd;
    logic          fwd1, fwd2, haz1, haz2, hazard;
    logic          load_en, accept;
    logic [DW-1:0] opa, opb, imm_ext;
    logic [NREGS-1:0] busy, busy_nxt;

    logic          ex_valid_q, ex_wen_q;
    logic [3:0]    ex_op_q;
    logic [AW-1:0] ex_rd_q;
    logic [DW-1:0] ex_a_q, ex_b_q, ex_imm_q;

    assign op    = bus.instr[31:28];
    assign rd    = bus.instr[27:24];
    assign rs1   = bus.instr[23:20];
    assign rs2   = bus.instr[19:16];
    assign imm16 = bus.instr[15:0];

    assign bus.raddr1 = rs1;
    assign bus.raddr2 = rs2;

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            4'h6: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            4'h7: writes_rd = 1'b1;
            4'h8: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            4'h9, 4'hA: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // regfile only updates on the edge, so a same-cycle writeback must bypass it
    assign fwd1 = bus.wb_en && (bus.wb_addr == rs1);
    assign fwd2 = bus.wb_en && (bus.wb_addr == rs2);
    assign opa  = fwd1 ? bus.wb_data : bus.rdata1;
    assign opb  = fwd2 ? bus.wb_data : bus.rdata2;

    assign haz1   = uses_rs1 && busy[rs1] && !fwd1;
    assign haz2   = uses_rs2 && busy[rs2] && !fwd2;
    assign hazard = haz1 || haz2;

    assign imm_ext = (op == OP_LUI) ? {imm16, {(DW-16){1'b0}}}
                                    : {{(DW-16){imm16[15]}}, imm16};

    assign load_en         = !ex_valid_q || bus.ex_ready;
    assign bus.instr_ready = rst && load_en && !hazard && (state == ST_RUN);
    assign accept          = bus.instr_valid && bus.instr_ready;

    always_comb begin
        state_nxt = state;
        if (state == ST_RUN && accept && op == OP_HALT)
            state_nxt = ST_HALT;
    end

    // clear first so a same-cycle set of the same register wins
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_en)
            busy_nxt[bus.wb_addr] = 1'b0;
        if (accept && writes_rd)
            busy_nxt[rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_rd_q    <= '0;
            ex_wen_q   <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_op_q    <= op;
            ex_rd_q    <= rd;
            ex_wen_q   <= writes_rd;
            ex_a_q     <= opa;
            ex_b_q     <= opb;
            ex_imm_q   <= imm_ext;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_op    = ex_op_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.ex_wen   = ex_wen_q;
    assign bus.ex_a     = ex_a_q;
    assign bus.ex_b     = ex_b_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.halted   = (state == ST_HALT);
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hazards, forwarding, ID/EX stall, immediates,
// scoreboard set-wins, HALT and reset mid-stall.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] rf [16];

    operand_fetch_if #(.DW(32), .AW(4)) bus ();

    operand_fetch #(.DW(32), .AW(4), .NREGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rdata1 = rf[bus.raddr1];
    assign bus.rdata2 = rf[bus.raddr2];

    always @(posedge clk)
        if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h11 * i;
        rf[1] = 32'h6D;
        rf[2] = 32'h65;
        rst             = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = mk(4'h1, 4'h3, 4'h1, 4'h2, 16'h0);
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.ex_ready    = 1'b1;
        #1;
        chk("rdy_in_rst", {31'b0, bus.instr_ready}, 32'h0);
        step();
        chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        chk("rst_ex_a", bus.ex_a, 32'h0);
        chk("rst_busy", {16'h0, dut.busy}, 32'h0);
        chk("rst_halted", {31'b0, bus.halted}, 32'h0);

        // ADD r3,r1,r2
        rst = 1'b1;
        #1;
        chk("add_rdy", {31'b0, bus.instr_ready}, 32'h1);
        step();
        chk("add_valid", {31'b0, bus.ex_valid}, 32'h1);
        chk("add_a", bus.ex_a, 32'h6D);
        chk("add_b", bus.ex_b, 32'h65);
        chk("add_rd", {28'h0, bus.ex_rd}, 32'h3);
        chk("add_wen", {31'b0, bus.ex_wen}, 32'h1);
        chk("add_busy", {16'h0, dut.busy}, 32'h0008);

        // ADD r4,r3,r0 blocked on r3 until its writeback arrives
        bus.instr = mk(4'h1, 4'h4, 4'h3, 4'h0, 16'h0);
        #1;
        chk("haz_rdy", {31'b0, bus.instr_ready}, 32'h0);
        step();
        chk("haz_exv", {31'b0, bus.ex_valid}, 32'h0);
        chk("haz_rdy2", {31'b0, bus.instr_ready}, 32'h0);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 4'h3;
        bus.wb_data = 32'hD2;
        #1;
        chk("fwd_rdy", {31'b0, bus.instr_ready}, 32'h1);
        step();
        bus.wb_en = 1'b0;
        chk("fwd_a", bus.ex_a, 32'hD2);
        chk("fwd_b", bus.ex_b, 32'h0);
        chk("fwd_rd", {28'h0, bus.ex_rd}, 32'h4);
        chk("fwd_busy", {16'h0, dut.busy}, 32'h0010);

        // execute stall for 3 cycles
        bus.ex_ready = 1'b0;
        bus.instr    = mk(4'h9, 4'h0, 4'h5, 4'h6, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", {31'b0, bus.instr_ready}, 32'h0);
            step();
            chk("stall_valid", {31'b0, bus.ex_valid}, 32'h1);
            chk("stall_a", bus.ex_a, 32'hD2);
            chk("stall_rd", {28'h0, bus.ex_rd}, 32'h4);
        end
        bus.ex_ready    = 1'b1;
        bus.instr_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, bus.ex_valid}, 32'h0);

        // ADDI r8,r1,-1
        bus.instr_valid = 1'b1;
        bus.instr       = mk(4'h6, 4'h8, 4'h1, 4'h0, 16'hFFFF);
        step();
        chk("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
        chk("addi_a", bus.ex_a, 32'h6D);
        chk("addi_op", {28'h0, bus.ex_op}, 32'h6);

        // LUI r9,0x1234
        bus.instr = mk(4'h7, 4'h9, 4'h0, 4'h0, 16'h1234);
        step();
        chk("lui_imm", bus.ex_imm, 32'h12340000);
        chk("lui_busy", {16'h0, dut.busy}, 32'h0310);

        // ST r5,r6 writes nothing
        bus.instr = mk(4'h9, 4'h0, 4'h5, 4'h6, 16'h0010);
        step();
        chk("st_wen", {31'b0, bus.ex_wen}, 32'h0);
        chk("st_a", bus.ex_a, 32'h55);
        chk("st_b", bus.ex_b, 32'h66);
        chk("st_imm", bus.ex_imm, 32'h10);
        chk("st_busy", {16'h0, dut.busy}, 32'h0310);

        // ADD r7 twice, second with a same-cycle writeback to r7: set wins
        bus.instr = mk(4'h1, 4'h7, 4'h1, 4'h2, 16'h0);
        step();
        chk("r7_busy", {16'h0, dut.busy}, 32'h0390);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 4'h7;
        bus.wb_data = 32'h77;
        step();
        bus.wb_en = 1'b0;
        chk("setwins_busy", {16'h0, dut.busy}, 32'h0390);

        // NOP naming busy registers in unused source fields must not stall
        bus.instr = mk(4'h0, 4'h0, 4'h4, 4'h9, 16'h0);
        #1;
        chk("nop_rdy", {31'b0, bus.instr_ready}, 32'h1);
        step();

        // HALT, then stall it in ID/EX and reset mid-stall
        bus.instr = mk(4'hF, 4'h5, 4'h0, 4'h0, 16'h0);
        step();
        bus.ex_ready = 1'b0;
        bus.instr    = mk(4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
        chk("halt_flag", {31'b0, bus.halted}, 32'h1);
        chk("halt_wen", {31'b0, bus.ex_wen}, 32'h0);
        chk("halt_op", {28'h0, bus.ex_op}, 32'hF);
        step();
        chk("halt_rdy", {31'b0, bus.instr_ready}, 32'h0);
        chk("halt_hold", {31'b0, bus.ex_valid}, 32'h1);
        bus.ex_ready = 1'b1;
        step();
        chk("halt_rdy2", {31'b0, bus.instr_ready}, 32'h0);
        chk("halt_flag2", {31'b0, bus.halted}, 32'h1);
        chk("halt_drain", {31'b0, bus.ex_valid}, 32'h0);
        bus.ex_ready = 1'b0;
        rst = 1'b0;
        step();
        chk("mrst_valid", {31'b0, bus.ex_valid}, 32'h0);
        chk("mrst_busy", {16'h0, dut.busy}, 32'h0);
        chk("mrst_halted", {31'b0, bus.halted}, 32'h0);
        chk("mrst_op", {28'h0, bus.ex_op}, 32'h0);
        rst = 1'b1;
        #1;
        chk("post_rdy", {31'b0, bus.instr_ready}, 32'h1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
